// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: latches data-side and fetch requests, arbitrates
// data side first, and moves each request over the byte-wide RAM bus little-endian.
module mem_ctrl #(
  parameter int               ADD_W  = 32,
  parameter int               DAT_W  = 32,
  parameter logic [ADD_W-1:0] IO_MSK = 32'h0003_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iLSB_En,
  input  logic             iLSB_Rw,
  input  logic [2:0]       iLSB_Len,
  input  logic [ADD_W-1:0] iLSB_Add,
  input  logic [DAT_W-1:0] iLSB_Dat,
  output logic             oLSB_En,
  output logic [DAT_W-1:0] oLSB_Dat,
  input  logic             iIF_En,
  input  logic [ADD_W-1:0] iIF_Add,
  output logic             oIF_En,
  output logic [DAT_W-1:0] oIF_Dat,
  input  logic             iROB_Mp,
  input  logic             iIO_Full,
  input  logic [7:0]       iMem_Din,
  output logic [7:0]       oMem_Dout,
  output logic [ADD_W-1:0] oMem_A,
  output logic             oMem_Wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [1:0]       last_q;
  logic [ADD_W-1:0] base_q;
  logic [DAT_W-1:0] wdat_q;
  logic [DAT_W-1:0] rdata_q;
  logic             is_if_q;

  logic             lsb_pend_q;
  logic             lsb_rw_q;
  logic [2:0]       lsb_len_q;
  logic [ADD_W-1:0] lsb_add_q;
  logic [DAT_W-1:0] lsb_dat_q;
  logic             if_pend_q;
  logic [ADD_W-1:0] if_add_q;

  logic [1:0]       lsb_last_d;
  logic [1:0]       byte_idx_d;
  logic [ADD_W-1:0] next_a_d;
  logic [DAT_W-1:0] rd_merged_d;
  logic             io_stall_d;

  // Index of the last byte (N-1); any length other than 1 or 2 moves a full word.
  always_comb begin
    case (lsb_len_q)
      3'd1:    lsb_last_d = 2'd0;
      3'd2:    lsb_last_d = 2'd1;
      default: lsb_last_d = 2'd3;
    endcase
  end

  // Read data arrives one cycle after its address, so op cycle k fills byte k-1.
  assign byte_idx_d = cnt_q[1:0] - 2'd1;
  assign next_a_d   = base_q + ADD_W'(cnt_q + 3'd1);
  assign io_stall_d = ((base_q & IO_MSK) == IO_MSK) && iIO_Full;

  always_comb begin
    rd_merged_d = rdata_q;
    rd_merged_d[{byte_idx_d, 3'b000} +: 8] = iMem_Din;
  end

  assign oMem_Wr = en && (state_q == WRITE) && !io_stall_d;
  assign oLSB_En = en && (state_q == DONE) && !is_if_q;
  assign oIF_En  = en && (state_q == DONE) && is_if_q && !iROB_Mp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      base_q     <= '0;
      wdat_q     <= '0;
      rdata_q    <= '0;
      is_if_q    <= 1'b0;
      lsb_pend_q <= 1'b0;
      lsb_rw_q   <= 1'b0;
      lsb_len_q  <= '0;
      lsb_add_q  <= '0;
      lsb_dat_q  <= '0;
      if_pend_q  <= 1'b0;
      if_add_q   <= '0;
      oLSB_Dat   <= '0;
      oIF_Dat    <= '0;
      oMem_A     <= '0;
      oMem_Dout  <= '0;
    end else if (en) begin
      if (iROB_Mp) if_pend_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          rdata_q <= '0;
          if (lsb_pend_q) begin
            lsb_pend_q <= 1'b0;
            is_if_q    <= 1'b0;
            base_q     <= lsb_add_q;
            wdat_q     <= lsb_dat_q;
            last_q     <= lsb_last_d;
            oMem_A     <= lsb_add_q;
            if (lsb_rw_q) begin
              state_q   <= WRITE;
              oMem_Dout <= lsb_dat_q[7:0];
            end else begin
              state_q <= READ;
            end
          end else if (if_pend_q && !iROB_Mp) begin
            if_pend_q <= 1'b0;
            is_if_q   <= 1'b1;
            base_q    <= if_add_q;
            last_q    <= 2'd3;
            oMem_A    <= if_add_q;
            state_q   <= READ;
          end
        end
        READ: begin
          if (is_if_q && iROB_Mp) begin
            state_q <= IDLE;
          end else begin
            if (cnt_q != 3'd0) rdata_q <= rd_merged_d;
            if (cnt_q == {1'b0, last_q} + 3'd1) begin
              state_q <= DONE;
              if (is_if_q) oIF_Dat <= rd_merged_d;
              else         oLSB_Dat <= rd_merged_d;
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q < {1'b0, last_q}) oMem_A <= next_a_d;
            end
          end
        end
        WRITE: begin
          if (!io_stall_d) begin
            if (cnt_q[1:0] == last_q) begin
              state_q <= DONE;
            end else begin
              cnt_q     <= cnt_q + 3'd1;
              oMem_A    <= next_a_d;
              oMem_Dout <= wdat_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Captures come last so a same-edge pulse overrides a start or flush clear.
      if (iLSB_En) begin
        lsb_pend_q <= 1'b1;
        lsb_rw_q   <= iLSB_Rw;
        lsb_len_q  <= iLSB_Len;
        lsb_add_q  <= iLSB_Add;
        lsb_dat_q  <= iLSB_Dat;
      end
      if (iIF_En) begin
        if_pend_q <= 1'b1;
        if_add_q  <= iIF_Add;
      end
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller sitting directly downstream of the load/store buffer's data-cache port, and of the instruction fetcher's fetch port.
- Latches one-cycle request pulses from both clients and arbitrates them, data side first.
- Serialises each request onto the byte-wide RAM bus, little-endian, and returns a one-cycle completion pulse with result data.
- Stalls IO-space writes while the IO buffer is full; flushes fetch traffic on misprediction.

Parameters:
ADD_W, 32, address width of requests and RAM bus
DAT_W, 32, request/response data width
IO_MSK, 32'h0003_0000, address bits that must all be set to mark an IO-space access

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
en  in  1  global ready; low freezes all state
iLSB_En  in  1  data request pulse, one cycle
iLSB_Rw  in  1  0: read, 1: write
iLSB_Len  in  3  byte count: 1, 2 or 4
iLSB_Add  in  ADD_W  base byte address
iLSB_Dat  in  DAT_W  store data; low Len bytes used
oLSB_En  out  1  data request complete; pulses for both reads and writes
oLSB_Dat  out  DAT_W  read result, zero-extended above Len bytes
iIF_En  in  1  fetch request pulse, always a 4-byte read
iIF_Add  in  ADD_W  fetch address
oIF_En  out  1  fetch complete pulse
oIF_Dat  out  DAT_W  fetched word
iROB_Mp  in  1  misprediction flush
iIO_Full  in  1  IO buffer full
iMem_Din  in  8  RAM read byte; valid one cycle after address
oMem_Dout  out  8  RAM write byte
oMem_A  out  ADD_W  RAM byte address
oMem_Wr  out  1  1: write, 0: read

Behaviour:
- Reset (rst=0, async): state IDLE, both pending slots empty, counter 0. All outputs 0.
- en=0: no state change. oMem_Wr forced 0. Completion pulses not asserted.
- Request latch:
  - At each enabled edge with iLSB_En=1, the LSB slot captures {Rw, Len, Add, Dat}.
  - At each enabled edge with iIF_En=1, the IF slot captures Add.
  - Each client has at most one outstanding request. A second pulse before completion is a protocol error; the newer capture overwrites.
- IDLE: on an edge with a pending slot, start the operation. The LSB slot wins if both are pending. Clear the slot, set cnt=0, go to READ or WRITE. An operation starts at the earliest on the edge after the latch edge.
- READ, N bytes:
  - In op cycle k (0..N-1): oMem_A=base+k, oMem_Wr=0.
  - iMem_Din is captured into byte k-1 of the result at op cycles 1..N.
  - After byte N-1 is captured, go to DONE.
- WRITE, N bytes:
  - In op cycle k: oMem_A=base+k, oMem_Dout=Dat[8k+7:8k], oMem_Wr=1. cnt advances each cycle.
  - IO stall: if (base & IO_MSK)==IO_MSK and iIO_Full=1, drive oMem_Wr=0 and do not advance cnt.
  - After byte N-1 is written, go to DONE.
- DONE: pulse oLSB_En or oIF_En for exactly one cycle with the data held stable, then return to IDLE.
  - Completion follows the last RAM cycle by 1 cycle for writes and by 2 cycles for reads.
  - A 4-byte read started at edge S completes with its pulse high during cycle S+5.
- Unused address/data outputs hold their last value. oMem_Wr is 0 outside active write cycles.
- Address arithmetic is mod 2^ADD_W. Wrap at 32'hFFFF_FFFF is permitted.
- iROB_Mp=1 at an enabled edge:
  - Clears the IF pending slot.
  - Aborts an in-flight fetch READ, or a fetch in DONE: return to IDLE, no oIF_En.
  - Data-side operations, pending or in flight, are unaffected.
  - If iIF_En=1 on the same edge, the new fetch is captured after the flush, so it survives.
- Simultaneous completion of one op and a latch on the other port: both occur. The new request starts from IDLE on the following edge.
- Invalid Len (0, 3, ≥5): treated as 4.

Test Plan:
- Reset mid-write:
  - Stimulus: SW to 0x100, rst pulled low during byte 1.
  - Required: outputs 0 immediately; after release, no further RAM writes and no oLSB_En.
- LW read:
  - Stimulus: RAM[0x200..0x203]=11,22,33,44; LSB pulse Rw=0 Len=4 Add=0x200.
  - Required: oMem_A sequence 0x200..0x203; oLSB_En one cycle with oLSB_Dat=0x44332211, 5 cycles after op start.
- LB zero-extend:
  - Stimulus: RAM[0x7]=0xF0; LB at 0x7.
  - Required: oLSB_Dat=0x000000F0.
- SH write:
  - Stimulus: SH Dat=0xDEADBEEF at 0x40.
  - Required: writes 0xEF@0x40 then 0xBE@0x41; oMem_Wr high exactly 2 cycles; oLSB_En 1 cycle later.
- Arbitration:
  - Stimulus: iLSB_En and iIF_En on the same edge.
  - Required: data op runs first, fetch starts the edge after oLSB_En; both complete once.
- Flush and IO stall:
  - Stimulus: iROB_Mp during a fetch at byte 2.
  - Required: no oIF_En.
  - Stimulus: SB to 0x30000 with iIO_Full=1 for 3 cycles.
  - Required: oMem_Wr low for those 3 cycles, then a single write and completion.
